// File: rtl/free_list.sv
// free_list: physical-register free list for the rename stage.
// Circular buffer of DEPTH = 2**P_ADDR_WIDTH - 2**L_ADDR_WIDTH tags with
// INSTR_COUNT alloc/release lanes and read-pointer checkpoints kept in
// lockstep with the RAT.
// Optional feature: define FREE_LIST_MIN_WATERMARK_EN to get a registered
// low-watermark of free_count on min_free; otherwise min_free is tied to DEPTH.

// Per-lane ring offset: base + off, wrapped into 0..DEPTH-1.
module free_list_lane #(
    parameter int PTR_W = 7,
    parameter int DEPTH = 96,
    parameter int OFF_W = 2
) (
    input  logic [PTR_W-1:0] base,
    input  logic [OFF_W-1:0] off,
    output logic [PTR_W-1:0] idx
);
    localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0] sum;

    // DEPTH is generally not a power of two, so wrap by compare-and-subtract.
    always_comb begin
        sum = {1'b0, base} + (PTR_W+1)'(off);
        idx = (sum >= DEPTH_P) ? PTR_W'(sum - DEPTH_P) : sum[PTR_W-1:0];
    end
endmodule

module free_list #(
    parameter int P_ADDR_WIDTH = 7,
    parameter int L_ADDR_WIDTH = 5,
    parameter int C_NUM        = 4,
    parameter int INSTR_COUNT  = 2,
    localparam int DEPTH = (1 << P_ADDR_WIDTH) - (1 << L_ADDR_WIDTH),
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int CK_W  = $clog2(C_NUM)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [INSTR_COUNT-1:0]                     alloc_req,
    output logic                                       alloc_ready,
    output logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0]   alloc_preg,
    input  logic [INSTR_COUNT-1:0]                     release_en,
    input  logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0]   release_preg,
    input  logic                                       take_checkpoint,
    input  logic                                       restore_checkpoint,
    input  logic [CK_W-1:0]                            new_checkpoint,
    output logic [CNT_W-1:0]                           free_count,
    output logic [CNT_W-1:0]                           min_free
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(INSTR_COUNT + 1);
    localparam logic [PTR_W:0]   DEPTH_P  = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_CX = (CNT_W+1)'(DEPTH);
    localparam logic [CK_W-1:0]  CK_LAST  = CK_W'(C_NUM - 1);

    logic [P_ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [CNT_W-1:0]        count;
    logic [PTR_W-1:0]        ckpt_ptr [C_NUM];
    logic [CK_W-1:0]         ckpt_head;

    logic [INSTR_COUNT:0][OFF_W-1:0] a_off, r_off;
    logic [INSTR_COUNT:0][PTR_W-1:0] rd_idx, wr_idx;
    logic [OFF_W-1:0]                n_alloc, n_rel;
    logic                            fire;
    logic [PTR_W-1:0]                ck_sel, rd_next;
    logic [CNT_W:0]                  reclaim, count_next;

    // Prefix popcounts: lane i's slot offset is the number of active lanes below it.
    always_comb begin
        a_off[0] = '0;
        r_off[0] = '0;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            a_off[i+1] = a_off[i] + OFF_W'(alloc_req[i]);
            r_off[i+1] = r_off[i] + OFF_W'(release_en[i]);
        end
    end

    assign n_alloc = a_off[INSTR_COUNT];
    assign n_rel   = r_off[INSTR_COUNT];

    // Entry INSTR_COUNT of each index vector is the advanced pointer.
    for (genvar g = 0; g <= INSTR_COUNT; g++) begin : g_lane
        free_list_lane #(.PTR_W(PTR_W), .DEPTH(DEPTH), .OFF_W(OFF_W)) u_rd (
            .base (rd_ptr),
            .off  (a_off[g]),
            .idx  (rd_idx[g])
        );
        free_list_lane #(.PTR_W(PTR_W), .DEPTH(DEPTH), .OFF_W(OFF_W)) u_wr (
            .base (wr_ptr),
            .off  (r_off[g]),
            .idx  (wr_idx[g])
        );
    end

    for (genvar g = 0; g < INSTR_COUNT; g++) begin : g_alloc
        assign alloc_preg[g] = mem[rd_idx[g]];
    end

    // Grant decision sees only the registered count; same-cycle releases land next cycle.
    assign alloc_ready = (count >= CNT_W'(n_alloc));
    assign fire        = alloc_ready & (|alloc_req) & ~restore_checkpoint;
    assign free_count  = count;
    assign ck_sel      = ckpt_ptr[new_checkpoint];

    // Wrong-path tags handed out since the checkpoint, then next pointer and count.
    always_comb begin
        if (rd_ptr >= ck_sel)
            reclaim = (CNT_W+1)'(rd_ptr - ck_sel);
        else
            reclaim = (CNT_W+1)'({1'b0, rd_ptr} + DEPTH_P - {1'b0, ck_sel});

        count_next = {1'b0, count} + (CNT_W+1)'(n_rel);
        rd_next    = rd_ptr;
        if (restore_checkpoint) begin
            count_next = count_next + reclaim;
            rd_next    = ck_sel;
        end else if (fire) begin
            count_next = count_next - (CNT_W+1)'(n_alloc);
            rd_next    = rd_idx[INSTR_COUNT];
        end
    end

    // Ring storage, pointers, count and checkpoint head.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= P_ADDR_WIDTH'((1 << L_ADDR_WIDTH) + i);
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= DEPTH_C;
            ckpt_head <= '0;
        end else begin
            for (int i = 0; i < INSTR_COUNT; i++)
                if (release_en[i]) mem[wr_idx[i]] <= release_preg[i];
            wr_ptr <= wr_idx[INSTR_COUNT];
            rd_ptr <= rd_next;
            count  <= count_next[CNT_W-1:0];
            if (restore_checkpoint)
                ckpt_head <= (new_checkpoint == CK_LAST) ? '0 : new_checkpoint + 1'b1;
            else if (take_checkpoint)
                ckpt_head <= (ckpt_head == CK_LAST) ? '0 : ckpt_head + 1'b1;
        end
    end

    // Checkpoint slots hold the pre-cycle read pointer, like the RAT snapshot.
    always_ff @(posedge clk) begin
        if (!rst && take_checkpoint && !restore_checkpoint)
            ckpt_ptr[ckpt_head] <= rd_ptr;
    end

    // More tags than the list can hold means a tag was returned twice.
    always_ff @(posedge clk) begin
        if (!rst) assert (count_next <= DEPTH_CX) else $fatal(1, "free_list: count overflow");
    end

`ifdef FREE_LIST_MIN_WATERMARK_EN
    // Low-watermark of the free count since reset.
    always_ff @(posedge clk) begin
        if (rst)
            min_free <= DEPTH_C;
        else if (count_next[CNT_W-1:0] < min_free)
            min_free <= count_next[CNT_W-1:0];
    end
`else
    assign min_free = DEPTH_C;
`endif

endmodule
